// File: rtl/pe_conv_sequencer_if.sv
// Handshake and PE-control bundle between the convolution sequencer (master)
// and its environment / PE instance (slave).
interface pe_conv_sequencer_if #(
  parameter int IDX_W  = 2,
  parameter int DATA_W = 8
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [2*IDX_W-1:0]   pe_s0;
  logic [2*IDX_W-1:0]   pe_s1;
  logic                 pe_rst;
  logic                 pe_init;
  logic [DATA_W-1:0]    pe_out;
  logic                 res_valid;
  logic [1:0]           res_idx;
  logic [DATA_W-1:0]    res0;
  logic [DATA_W-1:0]    res1;
  logic [DATA_W-1:0]    res2;
  logic [DATA_W-1:0]    res3;

  modport master (
    input  start, pe_out,
    output busy, done, pe_s0, pe_s1, pe_rst, pe_init,
           res_valid, res_idx, res0, res1, res2, res3
  );

  modport slave (
    output start, pe_out,
    input  busy, done, pe_s0, pe_s1, pe_rst, pe_init,
           res_valid, res_idx, res0, res1, res2, res3
  );
endinterface

// File: rtl/pe_conv_sequencer.sv
// Sequences one PE through a full OSZ x OSZ valid convolution of a window by a
// KSZ x KSZ kernel and captures each flushed PE result into a small register file.
module pe_conv_sequencer #(
  parameter int KSZ    = 3,
  parameter int OSZ    = 2,
  parameter int IDX_W  = 2,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pe_conv_sequencer_if.master   bus
);

  localparam int KW = (KSZ > 1) ? $clog2(KSZ) : 1;
  localparam int OW = (OSZ > 1) ? $clog2(OSZ) : 1;
  localparam logic [KW-1:0] KLAST = KW'(KSZ - 1);
  localparam logic [OW-1:0] OLAST = OW'(OSZ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       kr_q, kr_d, kc_q, kc_d;
  logic [OW-1:0]       orow_q, orow_d, ocol_q, ocol_d;
  logic                cap_q, cap_d;
  logic [1:0]          cap_idx_q, cap_idx_d;
  logic [DATA_W-1:0]   res_q [4];
  logic                res_valid_q;
  logic [1:0]          res_idx_q;

  logic                last_k, last_pos;
  logic [2*IDX_W-1:0]  s0_c, s1_c;
  logic                pe_rst_c, pe_init_c;

  assign last_k   = (kr_q == KLAST) && (kc_q == KLAST);
  assign last_pos = (orow_q == OLAST) && (ocol_q == OLAST);

  always_comb begin
    state_d   = state_q;
    kr_d      = kr_q;
    kc_d      = kc_q;
    orow_d    = orow_q;
    ocol_d    = ocol_q;
    cap_d     = 1'b0;
    cap_idx_d = cap_idx_q;
    s0_c      = '0;
    s1_c      = '0;
    pe_rst_c  = 1'b1;
    pe_init_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_MAC;
      end
      S_MAC: begin
        pe_rst_c = 1'b0;
        s0_c     = {IDX_W'(ocol_q) + IDX_W'(kc_q), IDX_W'(orow_q) + IDX_W'(kr_q)};
        s1_c     = {IDX_W'(kr_q), IDX_W'(kc_q)};
        // Counters stop on the last tap so FLUSH keeps presenting the final selects.
        if (last_k) begin
          state_d = S_FLUSH;
        end else if (kc_q == KLAST) begin
          kc_d = '0;
          kr_d = kr_q + KW'(1);
        end else begin
          kc_d = kc_q + KW'(1);
        end
      end
      S_FLUSH: begin
        pe_init_c = 1'b1;
        s0_c      = {IDX_W'(ocol_q) + IDX_W'(kc_q), IDX_W'(orow_q) + IDX_W'(kr_q)};
        s1_c      = {IDX_W'(kr_q), IDX_W'(kc_q)};
        cap_d     = 1'b1;
        cap_idx_d = 2'(int'(orow_q) * OSZ + int'(ocol_q));
        kr_d      = '0;
        kc_d      = '0;
        if (last_pos) begin
          orow_d  = '0;
          ocol_d  = '0;
          state_d = S_DONE;
        end else begin
          if (ocol_q == OLAST) begin
            ocol_d = '0;
            orow_d = orow_q + OW'(1);
          end else begin
            ocol_d = ocol_q + OW'(1);
          end
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      kr_q      <= '0;
      kc_q      <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
      cap_q     <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      kr_q      <= kr_d;
      kc_q      <= kc_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      cap_q     <= cap_d;
      cap_idx_q <= cap_idx_d;
    end
  end

  // The PE presents its latched result the cycle after FLUSH; capture it then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
    end else begin
      res_valid_q <= cap_q;
      if (cap_q) begin
        res_q[cap_idx_q] <= bus.pe_out;
        res_idx_q        <= cap_idx_q;
      end
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.pe_s0     = s0_c;
  assign bus.pe_s1     = s1_c;
  assign bus.pe_rst    = pe_rst_c;
  assign bus.pe_init   = pe_init_c;
  assign bus.res_valid = res_valid_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.res0      = res_q[0];
  assign bus.res1      = res_q[1];
  assign bus.res2      = res_q[2];
  assign bus.res3      = res_q[3];

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// Bench for pe_conv_sequencer: behavioural PE, random windows/kernels, per-cycle
// trace comparison against a trace and result model built from the convolution rules.
module tb_pe_conv_sequencer;
  localparam int KSZ    = 3;
  localparam int OSZ    = 2;
  localparam int IDX_W  = 2;
  localparam int DATA_W = 8;
  localparam int NCYC   = 1 + OSZ*OSZ*(KSZ*KSZ+1) + 1 + 1;  // through the IDLE cycle after DONE

  logic clk = 1'b0;
  logic rst_n;

  pe_conv_sequencer_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

  pe_conv_sequencer #(.KSZ(KSZ), .OSZ(OSZ), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural PE: clear on pe_rst, accumulate A[s0]*B[s1] mod 256, latch on pe_init.
  logic [7:0] amem [4][4];
  logic [7:0] bmem [4][4];
  logic [7:0] acc, pe_q;

  always_ff @(posedge clk) begin
    if (bus.pe_rst) acc <= '0;
    else acc <= acc + 8'(amem[bus.pe_s0[1:0]][bus.pe_s0[3:2]] * bmem[bus.pe_s1[3:2]][bus.pe_s1[1:0]]);
    if (bus.pe_init) pe_q <= acc;
  end
  assign bus.pe_out = pe_q;

  int n_chk = 0;
  int n_err = 0;
  logic [1:0] prev_idx = 2'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] conv_ref(input int orow, input int ocol);
    logic [7:0] s;
    s = '0;
    for (int kr = 0; kr < KSZ; kr++)
      for (int kc = 0; kc < KSZ; kc++)
        s = s + 8'(amem[orow+kr][ocol+kc] * bmem[kr][kc]);
    return s;
  endfunction

  function automatic logic [14:0] observe();
    return {bus.pe_s0, bus.pe_s1, bus.pe_rst, bus.pe_init, bus.busy, bus.done,
            bus.res_valid, bus.res_idx};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".ctl"}, 32'(observe()), 32'({4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}));
    chk({tag, ".res0"}, 32'(bus.res0), 32'd0);
    chk({tag, ".res1"}, 32'(bus.res1), 32'd0);
    chk({tag, ".res2"}, 32'(bus.res2), 32'd0);
    chk({tag, ".res3"}, 32'(bus.res3), 32'd0);
  endtask

  task automatic randomize_ab();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        amem[r][c] = 8'($urandom_range(0, 255));
        bmem[r][c] = (r < KSZ && c < KSZ) ? 8'($urandom_range(0, 255)) : 8'd0;
      end
  endtask

  // Called at a negedge. Accepts a start at the next edge, then checks NCYC cycles.
  task automatic run_conv(input string tag, input bit rnd, input bit hold, input bit noise,
                          input int abort_at);
    logic [11:0] ctl [NCYC+1];
    logic [7:0]  exp_res [4];
    logic [3:0]  s0, s1;
    logic [1:0]  idx;
    logic        rv;
    int          c;

    if (rnd) randomize_ab();
    for (int p = 0; p < OSZ*OSZ; p++) exp_res[p] = conv_ref(p / OSZ, p % OSZ);

    s0 = '0; s1 = '0;
    ctl[0] = '0;
    ctl[1] = {4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    c = 2;
    for (int p = 0; p < OSZ*OSZ; p++) begin
      for (int kr = 0; kr < KSZ; kr++)
        for (int kc = 0; kc < KSZ; kc++) begin
          s0 = {2'((p % OSZ) + kc), 2'((p / OSZ) + kr)};
          s1 = {2'(kr), 2'(kc)};
          ctl[c] = {s0, s1, 1'b0, 1'b0, 1'b1, 1'b0};
          c++;
        end
      ctl[c] = {s0, s1, 1'b1, 1'b1, 1'b1, 1'b0};
      c++;
    end
    ctl[c]   = {4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    ctl[c+1] = {4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    bus.start = 1'b1;
    @(posedge clk);
    for (int cy = 1; cy <= NCYC; cy++) begin
      @(negedge clk);
      idx = prev_idx;
      rv  = 1'b0;
      for (int p = 0; p < OSZ*OSZ; p++) begin
        if (cy >= 13 + 10*p) idx = 2'(p);
        if (cy == 13 + 10*p) rv = 1'b1;
      end
      chk($sformatf("%s.c%0d", tag, cy), 32'(observe()), 32'({ctl[cy], rv, idx}));
      if (cy == abort_at) begin
        bus.start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs({tag, ".abort"});
        @(negedge clk);
        rst_n = 1'b1;
        prev_idx = 2'd0;
        @(negedge clk);
        check_reset_outputs({tag, ".post_abort"});
        return;
      end
      if (cy == NCYC) bus.start = hold;
      else if (noise) bus.start = ((cy % 10) == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      else bus.start = hold;
    end
    prev_idx = 2'(OSZ*OSZ - 1);
    chk({tag, ".res0"}, 32'(bus.res0), 32'(exp_res[0]));
    chk({tag, ".res1"}, 32'(bus.res1), 32'(exp_res[1]));
    chk({tag, ".res2"}, 32'(bus.res2), 32'(exp_res[2]));
    chk({tag, ".res3"}, 32'(bus.res3), 32'(exp_res[3]));
  endtask

  initial begin
    logic [7:0] arows [4][4];
    logic [7:0] brows [3][3];
    arows = '{'{8'd1, 8'd2, 8'd3, 8'd4}, '{8'd2, 8'd3, 8'd4, 8'd5},
              '{8'd3, 8'd4, 8'd5, 8'd5}, '{8'd3, 8'd4, 8'd5, 8'd5}};
    brows = '{'{8'd9, 8'd8, 8'd7}, '{8'd8, 8'd7, 8'd6}, '{8'd7, 8'd6, 8'd5}};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        amem[r][c] = arows[r][c];
        bmem[r][c] = (r < 3 && c < 3) ? brows[r][c] : 8'd0;
      end

    rst_n = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_conv("directed", 1'b0, 1'b0, 1'b0, 0);
    chk("directed.c11", 32'(bus.res0), 32'd177);
    chk("directed.c12", 32'(bus.res1), 32'd235);
    chk("directed.c21", 32'(bus.res2), 32'd222);
    chk("directed.c22_wrap", 32'(bus.res3), 32'd18);

    run_conv("noise1", 1'b1, 1'b0, 1'b1, 0);
    run_conv("noise2", 1'b1, 1'b0, 1'b1, 0);
    run_conv("abort", 1'b1, 1'b0, 1'b0, 26);
    run_conv("after_abort", 1'b1, 1'b0, 1'b0, 0);
    run_conv("b2b1", 1'b1, 1'b1, 1'b0, 0);
    run_conv("b2b2", 1'b1, 1'b1, 1'b0, 0);
    run_conv("b2b3", 1'b1, 1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("idle_end", 32'(observe()), 32'({4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3}));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
